// File: rtl/riscv_pkg.sv
// Shared types and default widths for the core's memory-side blocks.
package riscv_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 64;
  localparam int unsigned DEFAULT_DATA_W = 64;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_FETCH,
    ARB_DATA
  } arb_state_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and data access. Data has fixed
// priority; each grant is latched and held for the memory latency, then a done pulse.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W  = DEFAULT_ADDR_W,
  parameter int unsigned DATA_W  = DEFAULT_DATA_W,
  parameter int unsigned MEM_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CntW = $clog2(MEM_LAT + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(MEM_LAT - 1);

  arb_state_t        state_q;
  logic [CntW-1:0]   cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              mem_we_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_done_q;
  logic              d_done_q;

  logic grant_data;
  logic grant_fetch;

  // A requester in its done cycle is masked so a still-high req is not re-granted.
  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (state_q == ARB_IDLE) begin
      if (d_req && !d_done_q) begin
        grant_data = 1'b1;
      end else if (if_req && !if_done_q) begin
        grant_fetch = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      mem_we_q   <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      mem_we_q  <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (grant_data) begin
            addr_q   <= d_addr;
            wdata_q  <= d_wdata;
            mem_we_q <= d_we;
            cnt_q    <= CntInit;
            state_q  <= ARB_DATA;
          end else if (grant_fetch) begin
            addr_q  <= if_addr;
            cnt_q   <= CntInit;
            state_q <= ARB_FETCH;
          end
        end
        ARB_FETCH: begin
          if (cnt_q == '0) begin
            if_rdata_q <= mem_rdata;
            if_done_q  <= 1'b1;
            state_q    <= ARB_IDLE;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        ARB_DATA: begin
          // mem_we_q is only ever high in the single busy cycle of a store.
          if (mem_we_q) begin
            d_done_q <= 1'b1;
            state_q  <= ARB_IDLE;
          end else if (cnt_q == '0) begin
            d_rdata_q <= mem_rdata;
            d_done_q  <= 1'b1;
            state_q   <= ARB_IDLE;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = mem_we_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_done   = if_done_q;
  assign d_done    = d_done_q;

  a_done_excl: assert property (@(posedge clk) disable iff (reset) !(if_done && d_done));
  a_we_in_data: assert property (@(posedge clk) disable iff (reset)
    mem_we |-> (state_q == ARB_DATA));
  a_we_single: assert property (@(posedge clk) disable iff (reset) mem_we |=> !mem_we);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: stimulus pushes expected completions, a forked monitor pops and compares.
module tb_mem_port_arbiter;

  localparam int unsigned AW = 64;
  localparam int unsigned DW = 64;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    int          cyc;
  } exp_t;

  logic          clk;
  logic          reset;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic [DW-1:0] if_rdata;
  logic          if_done;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic [DW-1:0] d_rdata;
  logic          d_done;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_we;
  logic [DW-1:0] mem_rdata;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t if_q[$];
  exp_t d_q[$];
  exp_t w_q[$];

  mem_port_arbiter #(
    .ADDR_W (AW),
    .DATA_W (DW),
    .MEM_LAT(2)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_rdata (if_rdata),
    .if_done  (if_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we   (mem_we),
    .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mem_model(input logic [63:0] a);
    case (a)
      64'h10:  return 64'h0000_0000_00A0_0093;
      64'h14:  return 64'h0000_0000_00B0_0113;
      64'h100: return 64'h55;
      default: return a ^ 64'hA5A5_A5A5_0000_0000;
    endcase
  endfunction

  // One registered stage plus the arbiter's sample edge gives a 2-cycle read.
  always @(posedge clk) mem_rdata <= mem_model(mem_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    int   c0;
    reset   = 1'b1;
    if_req  = 1'b1;
    d_req   = 1'b1;
    if_addr = 64'h40;
    d_addr  = 64'h80;
    d_we    = 1'b1;
    d_wdata = '1;

    fork
      forever begin
        @(negedge clk);
        if (!reset) begin
          if (if_done && d_done) check("done_excl", 64'(if_done & d_done), 64'd0);
          if (if_done) begin
            if (if_q.size() == 0) begin
              check("if_done_unexpected", 64'(if_done), 64'd0);
            end else begin
              e = if_q.pop_front();
              check("if_rdata", if_rdata, e.data);
              check("if_done_cycle", 64'(cyc), 64'(e.cyc));
            end
          end
          if (d_done) begin
            if (d_q.size() == 0) begin
              check("d_done_unexpected", 64'(d_done), 64'd0);
            end else begin
              e = d_q.pop_front();
              check("d_rdata", d_rdata, e.data);
              check("d_done_cycle", 64'(cyc), 64'(e.cyc));
            end
          end
          if (mem_we) begin
            if (w_q.size() == 0) begin
              check("mem_we_unexpected", 64'(mem_we), 64'd0);
            end else begin
              e = w_q.pop_front();
              check("wr_addr", mem_addr, e.addr);
              check("wr_data", mem_wdata, e.data);
              check("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
          end
        end
      end
    join_none

    // Reset held with both requests asserted.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_mem_we", 64'(mem_we), 64'd0);
      check("rst_dones", 64'({if_done, d_done}), 64'd0);
      check("rst_mem_addr", mem_addr, 64'd0);
    end
    check("rst_mem_wdata", mem_wdata, 64'd0);
    check("rst_if_rdata", if_rdata, 64'd0);
    check("rst_d_rdata", d_rdata, 64'd0);
    if_req  = 1'b0;
    d_req   = 1'b0;
    d_we    = 1'b0;
    d_wdata = '0;
    tick(1);
    reset = 1'b0;
    tick(1);
    @(negedge clk);
    check("idle_mem_addr", mem_addr, 64'd0);
    check("idle_mem_we", 64'(mem_we), 64'd0);

    // Single fetch.
    tick(1);
    c0 = cyc;
    if_req  = 1'b1;
    if_addr = 64'h10;
    if_q.push_back('{64'h10, 64'h0000_0000_00A0_0093, c0 + 3});
    tick(1);
    @(negedge clk);
    check("fetch_addr_1", mem_addr, 64'h10);
    check("fetch_we", 64'(mem_we), 64'd0);
    tick(1);
    @(negedge clk);
    check("fetch_addr_2", mem_addr, 64'h10);
    tick(1);
    if_req = 1'b0;
    tick(1);
    @(negedge clk);
    check("if_rdata_hold", if_rdata, 64'h0000_0000_00A0_0093);

    // Simultaneous load and fetch: data wins, fetch granted in the d_done cycle.
    tick(1);
    c0 = cyc;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 64'h100;
    if_req  = 1'b1;
    if_addr = 64'h14;
    d_q.push_back('{64'h100, 64'h55, c0 + 3});
    if_q.push_back('{64'h14, 64'h0000_0000_00B0_0113, c0 + 6});
    tick(1);
    @(negedge clk);
    check("load_addr", mem_addr, 64'h100);
    tick(2);
    d_req = 1'b0;
    tick(1);
    @(negedge clk);
    check("fetch_after_load_addr", mem_addr, 64'h14);
    tick(2);
    if_req = 1'b0;
    tick(1);

    // Store: one mem_we cycle, d_rdata keeps the previous load value.
    tick(1);
    c0 = cyc;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 64'h200;
    d_wdata = 64'h0000_0000_DEAD_BEEF;
    w_q.push_back('{64'h200, 64'h0000_0000_DEAD_BEEF, c0 + 1});
    d_q.push_back('{64'h200, 64'h55, c0 + 2});
    tick(2);
    d_req = 1'b0;
    d_we  = 1'b0;
    tick(1);
    @(negedge clk);
    check("store_we_low", 64'(mem_we), 64'd0);
    check("store_d_rdata", d_rdata, 64'h55);

    // Fetch request held through its done cycle: exactly one completion.
    tick(1);
    c0 = cyc;
    if_req  = 1'b1;
    if_addr = 64'h18;
    if_q.push_back('{64'h18, 64'hA5A5_A5A5_0000_0018, c0 + 3});
    tick(4);
    if_req = 1'b0;
    tick(6);
    check("held_req_single_done", 64'(if_q.size()), 64'd0);

    // Reset in the first busy cycle of a store.
    tick(1);
    c0 = cyc;
    d_req   = 1'b1;
    d_we    = 1'b1;
    d_addr  = 64'h300;
    d_wdata = 64'hCAFE;
    w_q.push_back('{64'h300, 64'hCAFE, c0 + 1});
    tick(1);
    @(negedge clk);
    #1;
    reset = 1'b1;
    d_req = 1'b0;
    d_we  = 1'b0;
    #1;
    check("abort_we_async", 64'(mem_we), 64'd0);
    tick(1);
    check("abort_d_done", 64'(d_done), 64'd0);
    reset = 1'b0;
    tick(2);
    @(negedge clk);
    check("abort_mem_addr", mem_addr, 64'd0);
    check("abort_d_rdata", d_rdata, 64'd0);

    // Arbiter back in IDLE: a fresh fetch completes with normal latency.
    tick(1);
    c0 = cyc;
    if_req  = 1'b1;
    if_addr = 64'h10;
    if_q.push_back('{64'h10, 64'h0000_0000_00A0_0093, c0 + 3});
    tick(4);
    if_req = 1'b0;
    tick(4);

    check("if_q_empty", 64'(if_q.size()), 64'd0);
    check("d_q_empty", 64'(d_q.size()), 64'd0);
    check("w_q_empty", 64'(w_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
